// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared arbitration constants, write FSM states and the round-robin pick helper
package mem_port_arbiter_pkg;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;
  localparam int   MAX_PORTS = 8;

  typedef enum logic {W_IDLE, W_BUSY} wstate_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First requester at or after ptr+1 (mod n); scanning downward lets the nearest one win.
  function automatic pick_t rr_pick(input logic [MAX_PORTS-1:0] req, input logic [2:0] ptr, input int n);
    pick_t p;
    int c;
    p = '0;
    for (int k = n; k >= 1; k--) begin
      c = (int'(ptr) + k) % n;
      if (req[c[2:0]]) begin
        p.found = 1'b1;
        p.idx   = c[2:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_id_fifo.sv
// mem_port_arbiter_id_fifo: in-order FIFO of issued read owner IDs with full/empty/count
module mem_port_arbiter_id_fifo #(
  parameter int W = 2,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = count == CNT_W'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage has no reset: entries are only read once count says they were written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between engines with independent read/write arbitration
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W = 26,
  parameter int DATA_W = 32,
  parameter int MAX_OUTSTANDING = 4,
  localparam int ID_W = $clog2(NUM_PORTS),
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        arb_mode,
  input  logic [ID_W-1:0]             sel,
  input  logic [NUM_PORTS-1:0]        eng_wvalid,
  output logic [NUM_PORTS-1:0]        eng_wready,
  input  logic [NUM_PORTS*ADDR_W-1:0] eng_waddr,
  input  logic [NUM_PORTS*DATA_W-1:0] eng_wdata,
  input  logic [NUM_PORTS-1:0]        eng_rvalid,
  output logic [NUM_PORTS-1:0]        eng_rready,
  input  logic [NUM_PORTS*ADDR_W-1:0] eng_raddr,
  output logic [NUM_PORTS*DATA_W-1:0] eng_rdata,
  output logic                        mem_wvalid,
  input  logic                        mem_wready,
  output logic [ADDR_W-1:0]           mem_waddr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_rvalid,
  input  logic                        mem_rack,
  output logic [ADDR_W-1:0]           mem_raddr,
  input  logic                        mem_rready,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [CNT_W-1:0]            outstanding,
  output logic                        err_unexp_rsp
);

  wstate_t                w_state;
  logic [ID_W-1:0]        w_id, w_ptr, r_ptr, r_id, head;
  logic [NUM_PORTS-1:0]   port_mask, pending;
  logic [MAX_PORTS-1:0]   w_req, r_req;
  pick_t                  w_pick, r_pick;
  logic                   w_busy, fifo_full, fifo_empty, push, pop;

  // Fixed mode narrows eligibility to the selected port; out-of-range sel shifts out to no port.
  assign port_mask = (arb_mode == ARB_RR) ? '1 : (NUM_PORTS'(1) << sel);
  assign w_req     = MAX_PORTS'(eng_wvalid & port_mask);
  assign r_req     = MAX_PORTS'(eng_rvalid & ~pending & port_mask);

  // Each channel searches from its own pointer.
  always_comb begin
    w_pick = rr_pick(w_req, 3'(w_ptr), NUM_PORTS);
    r_pick = rr_pick(r_req, 3'(r_ptr), NUM_PORTS);
  end

  // Write FSM: a grant latches the owner, so mode/sel changes cannot steal a busy write.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_ptr   <= ID_W'(NUM_PORTS - 1);
    end else if (w_state == W_IDLE) begin
      if (w_pick.found) begin
        w_state <= W_BUSY;
        w_id    <= ID_W'(w_pick.idx);
        w_ptr   <= ID_W'(w_pick.idx);
      end
    end else if (mem_wready) begin
      w_state <= W_IDLE;
    end
  end

  assign w_busy     = w_state == W_BUSY;
  assign mem_wvalid = w_busy;
  assign mem_waddr  = w_busy ? eng_waddr[w_id*ADDR_W +: ADDR_W] : '0;
  assign mem_wdata  = w_busy ? eng_wdata[w_id*DATA_W +: DATA_W] : '0;
  assign eng_wready = (w_busy && mem_wready) ? NUM_PORTS'(1) << w_id : '0;

  // Read issue is combinational and held off whenever the ID FIFO is full.
  assign r_id       = ID_W'(r_pick.idx);
  assign mem_rvalid = r_pick.found & ~fifo_full;
  assign mem_raddr  = mem_rvalid ? eng_raddr[r_id*ADDR_W +: ADDR_W] : '0;
  assign push       = mem_rvalid & mem_rack;
  assign pop        = mem_rready & ~fifo_empty;
  assign eng_rready = pop ? NUM_PORTS'(1) << head : '0;

  // Only the port owning the returning response sees data; all other slices stay zero.
  always_comb begin
    eng_rdata = '0;
    if (pop) eng_rdata[head*DATA_W +: DATA_W] = mem_rdata;
  end

  // Pending blocks a port from re-issuing while its read is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending       <= '0;
      r_ptr         <= ID_W'(NUM_PORTS - 1);
      err_unexp_rsp <= 1'b0;
    end else begin
      pending <= (pending | (push ? NUM_PORTS'(1) << r_id : '0)) & ~(pop ? NUM_PORTS'(1) << head : '0);
      if (push) r_ptr <= r_id;
      if (mem_rready && fifo_empty) err_unexp_rsp <= 1'b1;
    end
  end

  mem_port_arbiter_id_fifo #(
    .W    (ID_W),
    .DEPTH(MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (r_id),
    .pop  (pop),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(outstanding)
  );

endmodule
